avalon_multi_interval_timer: RTL and testbench

//  NUM_CH independent down-counting interval timers behind one 16-bit Avalon-MM slave; next-generation system tick/PWM-period source.

---
 rtl/avalon_multi_interval_timer.sv | 190 +++++++++++++++++++
 tb/tb_avalon_multi_interval_timer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_multi_interval_timer.sv
// Multi-channel down-counting interval timer with per-channel prescaler behind a 16-bit Avalon-MM slave.
// One combined level irq; the PENDING slot tells software which channels raised it.
module avalon_multi_interval_timer #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CNT_W        = 32,
  parameter logic [63:0] RESET_PERIOD = 64'd49999,
  parameter int unsigned CH_BITS      = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               chipselect,
  input  logic [CH_BITS+3:0] address,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  output logic               irq
);

  localparam int unsigned NUM_HW = CNT_W / 16;
  localparam int unsigned PS_W   = 16;
  localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RESET_PERIOD);

  localparam logic [3:0] SLOT_STATUS  = 4'd0;
  localparam logic [3:0] SLOT_CTRL    = 4'd1;
  localparam logic [3:0] SLOT_PER_LO  = 4'd2;
  localparam logic [3:0] SLOT_PER_HI  = 4'd5;
  localparam logic [3:0] SLOT_SNAP_LO = 4'd6;
  localparam logic [3:0] SLOT_SNAP_HI = 4'd9;
  localparam logic [3:0] SLOT_PRESC   = 4'd10;
  localparam logic [3:0] SLOT_PEND    = 4'd11;

  // Per-channel state
  logic [CNT_W-1:0] cnt       [NUM_CH];
  logic [CNT_W-1:0] period    [NUM_CH];
  logic [CNT_W-1:0] snap      [NUM_CH];
  logic [PS_W-1:0]  prescale  [NUM_CH];
  logic [PS_W-1:0]  presc_cnt [NUM_CH];
  logic [NUM_CH-1:0] run;
  logic [NUM_CH-1:0] to;
  logic [NUM_CH-1:0] cont;
  logic [NUM_CH-1:0] ito;
  logic [NUM_CH-1:0] reload_pend;

  logic [NUM_CH-1:0] ch_wr;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] timeout;
  logic [NUM_CH-1:0] pend;

  logic [CH_BITS-1:0] ch_sel;
  logic [3:0]         slot;
  logic               wr_en;
  logic [1:0]         per_hw;
  logic [1:0]         snap_hw;
  logic               per_slot_ok;
  logic               snap_slot_ok;
  logic [15:0]        rd_next;

  assign ch_sel  = address[CH_BITS+3:4];
  assign slot    = address[3:0];
  assign wr_en   = chipselect & ~write_n;
  assign per_hw  = 2'(slot - SLOT_PER_LO);
  assign snap_hw = 2'(slot - SLOT_SNAP_LO);

  // Halfword slots beyond the configured counter width are inert
  assign per_slot_ok  = (slot >= SLOT_PER_LO) && (slot <= SLOT_PER_HI) &&
                        (32'(per_hw) < NUM_HW);
  assign snap_slot_ok = (slot >= SLOT_SNAP_LO) && (slot <= SLOT_SNAP_HI) &&
                        (32'(snap_hw) < NUM_HW);

  function automatic logic [15:0] get_hw(input logic [CNT_W-1:0] v, input logic [1:0] hw);
    logic [63:0] e;
    e = 64'(v);
    return e[{hw, 4'b0000} +: 16];
  endfunction

  function automatic logic [CNT_W-1:0] put_hw(input logic [CNT_W-1:0] v, input logic [1:0] hw,
                                              input logic [15:0] d);
    logic [63:0] e;
    e = 64'(v);
    e[{hw, 4'b0000} +: 16] = d;
    return CNT_W'(e);
  endfunction

  // Per-channel strobes
  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      ch_wr[i]   = wr_en && (ch_sel == CH_BITS'(i));
      tick[i]    = run[i] && (presc_cnt[i] == '0);
      timeout[i] = tick[i] && (cnt[i] == '0);
      pend[i]    = to[i] & ito[i];
    end
  end

  assign irq = |pend;

  // Counter, prescaler and register-write datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        cnt[i]       <= RST_CNT;
        period[i]    <= RST_CNT;
        snap[i]      <= '0;
        prescale[i]  <= '0;
        presc_cnt[i] <= '0;
      end
      run         <= '0;
      to          <= '0;
      cont        <= '0;
      ito         <= '0;
      reload_pend <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (run[i]) begin
          presc_cnt[i] <= (presc_cnt[i] == '0) ? prescale[i] : presc_cnt[i] - PS_W'(1);
        end

        if (tick[i]) begin
          if (timeout[i]) begin
            cnt[i] <= period[i];
            to[i]  <= 1'b1;
            run[i] <= cont[i];
          end else begin
            cnt[i] <= cnt[i] - CNT_W'(1);
          end
        end

        if (ch_wr[i]) begin
          // A timeout landing on the clearing write keeps TO set
          if (slot == SLOT_STATUS && !timeout[i]) begin
            to[i] <= 1'b0;
          end
          if (slot == SLOT_CTRL) begin
            cont[i] <= writedata[1];
            ito[i]  <= writedata[0];
            if (writedata[2]) begin
              run[i]       <= 1'b1;
              presc_cnt[i] <= prescale[i];
            end else if (writedata[3]) begin
              run[i] <= 1'b0;
            end
          end
          if (per_slot_ok) begin
            period[i] <= put_hw(period[i], per_hw, writedata);
          end
          if (snap_slot_ok) begin
            snap[i] <= cnt[i];
          end
          if (slot == SLOT_PRESC) begin
            prescale[i] <= writedata;
          end
        end

        // Reload one cycle after a period write; beats any START in that cycle
        if (reload_pend[i]) begin
          cnt[i]       <= period[i];
          presc_cnt[i] <= prescale[i];
          run[i]       <= 1'b0;
        end
        reload_pend[i] <= ch_wr[i] && per_slot_ok;
      end
    end
  end

  // Read mux; unmapped channels and slots return zero
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (ch_sel == CH_BITS'(i)) begin
        case (slot)
          SLOT_STATUS: rd_next = {14'b0, run[i], to[i]};
          SLOT_CTRL:   rd_next = {14'b0, cont[i], ito[i]};
          4'd2, 4'd3, 4'd4, 4'd5: rd_next = get_hw(period[i], per_hw);
          4'd6, 4'd7, 4'd8, 4'd9: rd_next = get_hw(snap[i], snap_hw);
          SLOT_PRESC:  rd_next = prescale[i];
          SLOT_PEND:   rd_next = 16'(pend);
          default:     rd_next = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_avalon_multi_interval_timer.sv
// Bench for avalon_multi_interval_timer: register table plus timed interval/irq sequences,
// reads checked through an expected-value queue; a second 64-bit instance covers wide counters.
module tb_avalon_multi_interval_timer;

  logic        clk;
  logic        reset_n;
  logic        chipselect;
  logic [5:0]  address;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;
  logic [15:0] readdata64;
  logic        irq64;

  avalon_multi_interval_timer #(.NUM_CH(4), .CNT_W(32), .RESET_PERIOD(64'd49999), .CH_BITS(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  avalon_multi_interval_timer #(.NUM_CH(4), .CNT_W(64), .RESET_PERIOD(64'd49999), .CH_BITS(2)) u_dut64 (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .write_n(write_n), .writedata(writedata), .readdata(readdata64), .irq(irq64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        is64;
    logic [15:0] exp;
  } sb_t;

  typedef struct packed {
    logic        wr;
    logic        is64;
    logic [1:0]  ch;
    logic [3:0]  slot;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  sb_t   sb_q[$];
  string nm_q[$];
  vec_t  tbl[$];
  string tbl_nm[$];

  int   n_chk;
  int   n_err;
  logic rd_pend;

  task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
    end
  endtask

  // Scoreboard consumer: readdata is valid one edge after the address was driven
  always @(posedge clk) begin
    if (rd_pend) begin
      sb_t   e;
      string nm;
      #1;
      if (sb_q.size() == 0) begin
        check16("sb_underflow", 16'h0001, 16'h0000);
      end else begin
        e  = sb_q.pop_front();
        nm = nm_q.pop_front();
        check16(nm, e.is64 ? readdata64 : readdata, e.exp);
      end
    end
  end

  task automatic wr(input int ch, input int slot, input logic [15:0] d);
    address    = {2'(ch), 4'(slot)};
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_any(input logic is64, input int ch, input int slot, input logic [15:0] exp,
                        input string nm);
    address    = {2'(ch), 4'(slot)};
    chipselect = 1'b0;
    write_n    = 1'b1;
    rd_pend    = 1'b1;
    sb_q.push_back('{is64, exp});
    nm_q.push_back(nm);
    @(negedge clk);
    rd_pend = 1'b0;
  endtask

  task automatic rd(input int ch, input int slot, input logic [15:0] exp, input string nm);
    rd_any(1'b0, ch, slot, exp, nm);
  endtask

  task automatic rd64(input int ch, input int slot, input logic [15:0] exp, input string nm);
    rd_any(1'b1, ch, slot, exp, nm);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic add(input logic w, input logic is64, input int ch, input int slot,
                     input logic [15:0] wd, input logic [15:0] exp, input string nm);
    tbl.push_back('{w, is64, 2'(ch), 4'(slot), wd, exp});
    tbl_nm.push_back(nm);
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    rd_pend    = 1'b0;
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = '0;
    writedata  = '0;

    // {write?, 64-bit dut?, ch, slot, wdata, expected read}
    add(0, 0, 0, 0,  16'h0000, 16'h0000, "rst_status");
    add(0, 0, 0, 1,  16'h0000, 16'h0000, "rst_ctrl");
    add(0, 0, 0, 2,  16'h0000, 16'hC34F, "rst_per_hw0");
    add(0, 0, 0, 3,  16'h0000, 16'h0000, "rst_per_hw1");
    add(0, 0, 3, 2,  16'h0000, 16'hC34F, "rst_per3_hw0");
    add(0, 0, 0, 4,  16'h0000, 16'h0000, "per_hw2_oob");
    add(0, 0, 1, 6,  16'h0000, 16'h0000, "rst_snap");
    add(0, 0, 2, 10, 16'h0000, 16'h0000, "rst_presc");
    add(0, 0, 0, 11, 16'h0000, 16'h0000, "rst_pending");
    add(0, 1, 0, 2,  16'h0000, 16'hC34F, "rst64_per_hw0");
    add(0, 1, 0, 5,  16'h0000, 16'h0000, "rst64_per_hw3");
    add(1, 0, 1, 10, 16'h1234, 16'h1234, "presc_rw");
    add(1, 0, 1, 12, 16'hFFFF, 16'h0000, "slot12_ign");
    add(1, 0, 1, 4,  16'h5555, 16'h0000, "per_hw2_wr_ign");
    add(0, 1, 1, 4,  16'h0000, 16'h5555, "per64_hw2_rw");
    add(1, 0, 2, 1,  16'h000B, 16'h0003, "ctrl_rw");
    add(0, 0, 2, 0,  16'h0000, 16'h0000, "stop_no_run");
    add(1, 0, 2, 1,  16'h0000, 16'h0000, "ctrl_clr");

    repeat (3) @(negedge clk);
    check16("rst_readdata", readdata, 16'h0000);
    check16("rst_readdata64", readdata64, 16'h0000);
    check16("rst_irq", 16'(irq), 16'h0000);
    reset_n = 1'b1;
    idle(1);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) wr(int'(tbl[i].ch), int'(tbl[i].slot), tbl[i].wdata);
      rd_any(tbl[i].is64, int'(tbl[i].ch), int'(tbl[i].slot), tbl[i].exp, tbl_nm[i]);
    end

    // T1: ch0 period 4, continuous, irq every 5 clocks
    wr(0, 2, 16'd4); wr(0, 3, 16'd0); wr(0, 10, 16'd0); wr(0, 1, 16'h0007);
    idle(4); check16("t1_pre_to", 16'(irq), 16'h0000);
    idle(1); check16("t1_to", 16'(irq), 16'h0001);
    rd(0, 0, 16'h0003, "t1_status");
    wr(0, 0, 16'h0000); check16("t1_clr", 16'(irq), 16'h0000);
    idle(2); check16("t1_pre_reto", 16'(irq), 16'h0000);
    idle(1); check16("t1_reto", 16'(irq), 16'h0001);
    wr(0, 1, 16'h0008); check16("t1_ito_off", 16'(irq), 16'h0000);
    rd(0, 0, 16'h0001, "t1_to_kept");
    rd(0, 1, 16'h0000, "t1_ctrl_rd");
    wr(0, 0, 16'h0000);

    // T2: ch1 period 2, prescale 3, one-shot: timeout 12 clocks after START
    wr(1, 2, 16'd2); wr(1, 3, 16'd0); wr(1, 10, 16'd3); wr(1, 1, 16'h0004);
    idle(11);
    rd(1, 0, 16'h0002, "t2_running");
    rd(1, 0, 16'h0001, "t2_oneshot");
    wr(1, 6, 16'h0000);
    rd(1, 6, 16'd2, "t2_reload");
    check16("t2_no_irq", 16'(irq), 16'h0000);

    // T3: ch2 period 100, snapshot after 10 ticks
    wr(2, 2, 16'd100); wr(2, 3, 16'd0); wr(2, 10, 16'd0); wr(2, 1, 16'h0006);
    idle(10);
    wr(2, 6, 16'hABCD);
    rd(2, 6, 16'd90, "t3_snap_hw0");
    rd(2, 7, 16'd0, "t3_snap_hw1");
    idle(3);
    rd(2, 6, 16'd90, "t3_snap_hold");
    wr(2, 1, 16'h0008);

    // T4: ch0 and ch3 time out with ITO set
    wr(0, 2, 16'd1); wr(3, 2, 16'd1); wr(0, 1, 16'h0005); wr(3, 1, 16'h0005);
    idle(4);
    rd(1, 11, 16'h0009, "t4_pend_ch1");
    rd(2, 11, 16'h0009, "t4_pend_ch2");
    check16("t4_irq", 16'(irq), 16'h0001);
    wr(0, 0, 16'h0000);
    rd(3, 11, 16'h0008, "t4_pend_after_clr");
    check16("t4_irq_ch3", 16'(irq), 16'h0001);
    wr(3, 0, 16'h0000);
    check16("t4_irq_clr", 16'(irq), 16'h0000);

    // T5: clear racing a timeout, then period write while running
    wr(0, 1, 16'h0007);
    idle(2);
    wr(0, 0, 16'h0000); check16("t5_clr", 16'(irq), 16'h0000);
    wr(0, 0, 16'h0000); check16("t5_race", 16'(irq), 16'h0001);
    rd(0, 0, 16'h0003, "t5_status");
    wr(0, 2, 16'd7);
    wr(0, 1, 16'h0007);
    rd(0, 0, 16'h0001, "t5_reload_stop");
    wr(0, 6, 16'h0000);
    rd(0, 6, 16'd7, "t5_cnt_reload");
    rd(0, 2, 16'd7, "t5_period");
    check16("t5_irq", 16'(irq), 16'h0001);
    wr(0, 0, 16'h0000);
    wr(0, 1, 16'h0000);

    // T6: 64-bit counter, period 2^48, reset pulsed mid-count
    wr(0, 2, 16'd0); wr(0, 3, 16'd0); wr(0, 4, 16'd0); wr(0, 5, 16'd1);
    wr(0, 10, 16'd0); wr(0, 1, 16'h0007);
    idle(5);
    wr(0, 6, 16'h0000);
    rd64(0, 8, 16'hFFFF, "t6_snap_hw2");
    rd64(0, 9, 16'h0000, "t6_snap_hw3");
    rd(0, 5, 16'h0000, "t6_hw3_oob32");
    rd64(0, 5, 16'h0001, "t6_per_hw3");
    idle(2);
    check16("t6_irq_pre", 16'(irq), 16'h0001);
    #2 reset_n = 1'b0;
    #1;
    check16("t6_rst_rd64", readdata64, 16'h0000);
    check16("t6_rst_rd", readdata, 16'h0000);
    check16("t6_rst_irq", 16'(irq), 16'h0000);
    check16("t6_rst_irq64", 16'(irq64), 16'h0000);
    idle(2);
    reset_n = 1'b1;
    rd64(0, 0, 16'h0000, "t6_status");
    rd64(0, 1, 16'h0000, "t6_ctrl");
    rd64(0, 2, 16'hC34F, "t6_per_hw0");
    rd64(0, 5, 16'h0000, "t6_per_hw3_rst");
    rd64(0, 8, 16'h0000, "t6_snap_rst");
    rd64(0, 10, 16'h0000, "t6_presc_rst");
    rd(0, 0, 16'h0000, "t6_status32");
    check16("t6_irq64_post", 16'(irq64), 16'h0000);

    idle(1);
    check16("sb_drained", 16'(sb_q.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
